seq_checker: RTL and testbench
==============================

// Module: seq_checker
// PURPOSE
//   Receive-side checker for the free-running modulo-2^WIDTH binary counter stream.
//   - Samples din on din_valid and hunts for the increment-by-one sequence.
//   - Declares lock after LOCK_CNT consecutive in-sequence samples.
//   - Once locked, flywheels the expected value, flags and counts each mismatch,
//     and drops lock after UNLOCK_CNT consecutive mismatches.
//   - Sits on the consumer side of any counter-driven stimulus/status bus.
// PARAMETERS
//   WIDTH       3  width of the checked count value
//   LOCK_CNT    4  consecutive in-sequence samples (incl. first) to reach lock; >=2
//   UNLOCK_CNT  2  consecutive mismatches while locked that drop lock; >=1
//   ERR_W       8  width of saturating error counter
// PORTS
//   clk        in   1      clock; all state updates on posedge
//   rst        in   1      synchronous reset, active-high
//   din        in   WIDTH  counter value under check
//   din_valid  in   1      din is a sample this cycle
//   clr_err    in   1      synchronous clear of err_count
//   locked     out  1      checker in lock (LOCKED or SLIP)
//   err        out  1      one-cycle pulse: sampled din mismatched while locked
//   err_count  out  ERR_W  saturating count of err pulses since reset/clear
//   expected   out  WIDTH  value the next valid sample must carry
// BEHAVIOUR
//   Outputs and state: all registered. On a clk edge with rst=1:
//     state=HUNT, locked=0, err=0, err_count=0, expected=0, match/miss counters=0.
//   Arithmetic: nxt(x) = (x+1) mod 2^WIDTH. Wrap (2^WIDTH-1 -> 0) is in-sequence.
//   din_valid=0: no state/counter/expected change; err=0 that cycle.
//   FSM (evaluated only when din_valid=1):
//     HUNT   : expected<=nxt(din), match=1 -> SYNC.
//     SYNC   : din==expected:
//                match++, expected<=nxt(din); match reaching LOCK_CNT -> LOCKED.
//              else: expected<=nxt(din), match=1, stay SYNC. No err in SYNC.
//     LOCKED : din==expected: expected<=nxt(expected).
//              else: err<=1, count++, miss=1, expected<=nxt(expected) (flywheel);
//                    if UNLOCK_CNT==1 -> HUNT else -> SLIP.
//     SLIP   : din==expected: miss=0, expected<=nxt(expected) -> LOCKED.
//              else: err<=1, count++, miss++, expected<=nxt(expected);
//                    miss reaching UNLOCK_CNT -> HUNT.
//   Entering HUNT from SLIP: locked=0 from that edge.
//   locked = (state==LOCKED || state==SLIP); no glitch when moving between them.
//   Latency:
//     - err asserts on the edge that samples the bad din; it is visible the
//       following cycle.
//     - locked rises on the edge that samples the LOCK_CNT-th good value.
//   err_count:
//     - Saturates at all-ones and holds.
//     - clr_err alone -> 0.
//     - clr_err together with an error -> 1.
//   rst has priority over every input, including mid-sequence and mid-SLIP.
// TESTING
//   1 rst, then din=0,1,2,3 valid every cycle
//     -> locked=1 after 4th sample; err never high; expected=4.
//   2 locked, stream 5,6,7,0,1
//     -> no err; locked held; expected=2 after last sample.
//   3 locked, expected=4, feed 2 then 5
//     -> one err pulse; locked stays 1 (SLIP then LOCKED); err_count=1; expected=6.
//   4 locked, feed 2 valid mismatches
//     -> 2 err pulses; err_count=2; locked=0 (HUNT).
//     Then feed 4 in-sequence values -> locked=1.
//   5 locked, din_valid low 3 cycles between samples 3 and 4
//     -> no change in any output. Then, with ERR_W=2, force 5 errors
//     -> err_count=3 (saturated). clr_err with an error -> err_count=1.
//   6 locked, err_count=2, rst high for one edge
//     -> locked=0, err_count=0, expected=0, err=0 on that edge.

Source files
------------

// File: rtl/seq_checker.sv
// rtl/seq_checker.sv - lock/flywheel checker for a free-running modulo-2^WIDTH counter stream
module seq_checker #(
    parameter int WIDTH      = 3,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             clr_err,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_SLIP   = 2'd3;

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);

    localparam logic [MW-1:0]    MATCH_ONE   = 1;
    localparam logic [MW-1:0]    MATCH_LAST  = MW'(LOCK_CNT - 1);
    localparam logic [UW-1:0]    MISS_ONE    = 1;
    localparam logic [UW-1:0]    MISS_LAST   = UW'(UNLOCK_CNT - 1);
    localparam logic [WIDTH-1:0] VAL_ONE     = 1;
    localparam logic [ERR_W-1:0] ERR_ONE     = 1;
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    logic [1:0]       state;
    logic [MW-1:0]    match_cnt;
    logic [UW-1:0]    miss_cnt;
    logic [WIDTH-1:0] din_nxt;
    logic [WIDTH-1:0] exp_nxt;
    logic             in_lock;
    logic             hit_err;

    assign din_nxt = din + VAL_ONE;
    assign exp_nxt = expected + VAL_ONE;
    assign in_lock = (state == ST_LOCKED) || (state == ST_SLIP);
    assign hit_err = din_valid && in_lock && (din != expected);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HUNT;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
            expected  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            err <= hit_err;

            // An error in the same cycle as a clear leaves a count of one.
            if (hit_err) begin
                if (clr_err)
                    err_count <= ERR_ONE;
                else if (err_count != ERR_MAX)
                    err_count <= err_count + ERR_ONE;
            end else if (clr_err) begin
                err_count <= '0;
            end

            if (din_valid) begin
                case (state)
                    ST_HUNT: begin
                        expected  <= din_nxt;
                        match_cnt <= MATCH_ONE;
                        state     <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        expected <= din_nxt;
                        if (din == expected) begin
                            if (match_cnt == MATCH_LAST) begin
                                state    <= ST_LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + MATCH_ONE;
                            end
                        end else begin
                            match_cnt <= MATCH_ONE;
                        end
                    end
                    ST_LOCKED: begin
                        // Flywheel: expected advances regardless of what arrived.
                        expected <= exp_nxt;
                        if (din != expected) begin
                            miss_cnt <= MISS_ONE;
                            if (UNLOCK_CNT == 1) begin
                                state  <= ST_HUNT;
                                locked <= 1'b0;
                            end else begin
                                state <= ST_SLIP;
                            end
                        end
                    end
                    default: begin
                        expected <= exp_nxt;
                        if (din == expected) begin
                            miss_cnt <= '0;
                            state    <= ST_LOCKED;
                        end else if (miss_cnt == MISS_LAST) begin
                            state  <= ST_HUNT;
                            locked <= 1'b0;
                        end else begin
                            miss_cnt <= miss_cnt + MISS_ONE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_checker.sv
// tb/tb_seq_checker.sv - self-checking bench for seq_checker against a run-length reference model
module tb_seq_checker;

    localparam int LOCK   = 4;
    localparam int UNLOCK = 2;
    localparam int MODV   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din_valid = 1'b0;
    logic       clr_err = 1'b0;
    logic [2:0] din = '0;

    logic       locked_a, err_a, locked_b, err_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [2:0] exp_a, exp_b;

    always #5 clk = ~clk;

    seq_checker #(.WIDTH(3), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK), .ERR_W(8)) dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_err(clr_err),
        .locked(locked_a), .err(err_a), .err_count(cnt_a), .expected(exp_a)
    );

    seq_checker #(.WIDTH(3), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK), .ERR_W(2)) dut_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_err(clr_err),
        .locked(locked_b), .err(err_b), .err_count(cnt_b), .expected(exp_b)
    );

    int tests = 0;
    int fails = 0;
    bit cmp_on = 1'b0;

    // Reference: m_good is the length of the current in-sequence run while unlocked
    // (0 means nothing collected yet), m_miss the current run of misses while locked.
    int m_lock, m_good, m_miss, m_exp, m_err, m_cnt8, m_cnt2;

    function automatic int sat_inc(input int v, input int vmax);
        return (v < vmax) ? v + 1 : v;
    endfunction

    task automatic mdl(input logic r, input logic v, input int d, input logic c);
        int e;
        if (r) begin
            m_lock = 0; m_good = 0; m_miss = 0; m_exp = 0; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
            return;
        end
        e = 0;
        if (v) begin
            if (m_lock == 0) begin
                if (m_good == 0 || d != m_exp) m_good = 1;
                else m_good = m_good + 1;
                m_exp = (d + 1) % MODV;
                if (m_good == LOCK) begin
                    m_lock = 1;
                    m_miss = 0;
                end
            end else begin
                if (d == m_exp) begin
                    m_miss = 0;
                end else begin
                    e = 1;
                    m_miss = m_miss + 1;
                    if (m_miss == UNLOCK) begin
                        m_lock = 0;
                        m_good = 0;
                    end
                end
                m_exp = (m_exp + 1) % MODV;
            end
        end
        m_err = e;
        if (e == 1) begin
            m_cnt8 = c ? 1 : sat_inc(m_cnt8, 255);
            m_cnt2 = c ? 1 : sat_inc(m_cnt2, 3);
        end else if (c) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic v, input int d, input logic c);
        rst = r;
        din_valid = v;
        din = 3'(d);
        clr_err = c;
        @(posedge clk);
        mdl(r, v, d, c);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("locked_a", {31'd0, locked_a}, m_lock);
            chk("err_a", {31'd0, err_a}, m_err);
            chk("expected_a", {29'd0, exp_a}, m_exp);
            chk("err_count_a", {24'd0, cnt_a}, m_cnt8);
            chk("locked_b", {31'd0, locked_b}, m_lock);
            chk("expected_b", {29'd0, exp_b}, m_exp);
            chk("err_count_b", {30'd0, cnt_b}, m_cnt2);
        end
    end

    initial begin
        int src;
        int d;
        logic r, v, c;

        step(1, 0, 0, 0);
        cmp_on = 1'b1;
        chk("rst_locked", {31'd0, locked_a}, 0);
        chk("rst_expected", {29'd0, exp_a}, 0);
        chk("rst_count", {24'd0, cnt_a}, 0);

        // acquire lock on 0,1,2,3
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 2, 0);
        chk("t1_prelock", {31'd0, locked_a}, 0);
        step(0, 1, 3, 0);
        chk("t1_lock", {31'd0, locked_a}, 1);
        chk("t1_expected", {29'd0, exp_a}, 4);

        // clean stream across the wrap
        for (int i = 4; i < 10; i++) step(0, 1, i % MODV, 0);
        chk("t2_locked", {31'd0, locked_a}, 1);
        chk("t2_expected", {29'd0, exp_a}, 2);
        chk("t2_count", {24'd0, cnt_a}, 0);

        // single miss: SLIP then back to LOCKED
        step(0, 1, 2, 0);
        step(0, 1, 3, 0);
        step(0, 1, 2, 0);
        chk("t3_err", {31'd0, err_a}, 1);
        chk("t3_slip_locked", {31'd0, locked_a}, 1);
        step(0, 1, 5, 0);
        chk("t3_err_clear", {31'd0, err_a}, 0);
        chk("t3_count", {24'd0, cnt_a}, 1);
        chk("t3_expected", {29'd0, exp_a}, 6);

        // two misses drop lock, then reacquire
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("t4_unlocked", {31'd0, locked_a}, 0);
        chk("t4_count", {24'd0, cnt_a}, 3);
        chk("t4_expected", {29'd0, exp_a}, 0);
        step(0, 1, 3, 0);
        step(0, 1, 4, 0);
        step(0, 1, 5, 0);
        chk("t4_prelock", {31'd0, locked_a}, 0);
        step(0, 1, 6, 0);
        chk("t4_relock", {31'd0, locked_a}, 1);
        chk("t4_expected2", {29'd0, exp_a}, 7);

        // clear, idle gaps, then saturation and clear-with-error
        step(0, 0, 0, 1);
        chk("t5_clr", {24'd0, cnt_a}, 0);
        step(0, 1, 7, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, $urandom_range(0, 7), 0);
            chk("t5_idle_expected", {29'd0, exp_a}, 0);
            chk("t5_idle_locked", {31'd0, locked_a}, 1);
        end
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, (m_exp + 3) % MODV, 0);
            step(0, 1, m_exp, 0);
        end
        chk("t5_count8", {24'd0, cnt_a}, 5);
        chk("t5_count2_sat", {30'd0, cnt_b}, 3);
        step(0, 1, (m_exp + 3) % MODV, 1);
        chk("t5_clr_err_a", {24'd0, cnt_a}, 1);
        chk("t5_clr_err_b", {30'd0, cnt_b}, 1);

        // reset mid-SLIP wins over a valid sample
        step(0, 1, m_exp, 0);
        step(0, 1, (m_exp + 3) % MODV, 0);
        chk("t6_count", {24'd0, cnt_a}, 2);
        chk("t6_slip_locked", {31'd0, locked_a}, 1);
        step(1, 1, 1, 0);
        chk("t6_rst_locked", {31'd0, locked_a}, 0);
        chk("t6_rst_count", {24'd0, cnt_a}, 0);
        chk("t6_rst_expected", {29'd0, exp_a}, 0);
        chk("t6_rst_err", {31'd0, err_a}, 0);

        // randomized stream: mostly counting, with corruption, jumps, gaps, clears, resets
        src = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 49) == 0);
            d = src;
            if ($urandom_range(0, 15) == 0) d = $urandom_range(0, 7);
            if ($urandom_range(0, 99) == 0) src = $urandom_range(0, 7);
            step(r, v, d, c);
            if (v) src = (src + 1) % MODV;
        end

        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
